// File: rtl/rv_regfile_pkg.sv
// Shared types and sizes for the register-file writeback scheduler.
package rv_regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_X0 = '0;

    // Port 0 is the ALU writeback path, port 1 the LSU writeback path.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// port that did not win the previous grant.
module rr_arbiter2
    import rv_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_port_e last_grant;

    // Grant decode; ties resolved against the previous winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == WB_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner of every handshake; reset favours the ALU on the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= WB_LSU;
        end else if (|gnt) begin
            last_grant <= gnt[1] ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the single register-file write port between the ALU and LSU
// writeback paths and tracks outstanding producers in a busy scoreboard.
module regfile_wb_scheduler
    import rv_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    input  logic            alu_wb_valid,
    output logic            alu_wb_ready,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            lsu_wb_valid,
    output logic            lsu_wb_ready,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            sb_empty
);

    logic [1:0]      gnt;
    logic            handshake;
    reg_addr_t       win_rd;
    logic [XLEN-1:0] win_data;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({lsu_wb_valid, alu_wb_valid}),
        .gnt   (gnt)
    );

    assign alu_wb_ready = gnt[0];
    assign lsu_wb_ready = gnt[1];
    assign handshake    = |gnt;

    // Select the granted requester's destination and payload.
    always_comb begin
        win_rd   = gnt[1] ? lsu_wb_rd   : alu_wb_rd;
        win_data = gnt[1] ? lsu_wb_data : alu_wb_data;
    end

    // Write stage: register the winner; a write to x0 is accepted but never enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (handshake) begin
            rf_we    <= (win_rd != REG_X0);
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard next state: commit clears, flush wipes, and a new issue beats a same-cycle clear.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (flush) begin
            busy_next = '0;
        end else if (issue_valid && (issue_rd != REG_X0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[issue_rs1];
    assign rs2_busy = busy[issue_rs2];
    assign rd_busy  = busy[issue_rd];
    assign sb_empty = ~|busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all mirrored by a behavioural model checked every cycle.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        alu_wb_valid, alu_wb_ready;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_empty;

    int vectors     = 0;
    int miscompares = 0;

    regfile_wb_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rd_busy      (rd_busy),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_ready (lsu_wb_ready),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sb_empty     (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          model_ok = 0;
    bit          m_busy [32];
    int          m_last;          // 0 = ALU won last, 1 = LSU won last
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wdata;

    // -1 none, 0 ALU, 1 LSU
    function automatic int model_grant();
        if (alu_wb_valid && lsu_wb_valid) return (m_last == 1) ? 0 : 1;
        if (alu_wb_valid) return 0;
        if (lsu_wb_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            model_ok = 1;
            foreach (m_busy[i]) m_busy[i] = 0;
            m_last  = 1;
            m_we    = 0;
            m_waddr = 0;
            m_wdata = '0;
        end else if (model_ok) begin
            g = model_grant();
            if (m_we) m_busy[m_waddr] = 0;
            if (flush) begin
                foreach (m_busy[i]) m_busy[i] = 0;
            end else if (issue_valid && issue_rd != 0) begin
                m_busy[issue_rd] = 1;
            end
            if (g >= 0) begin
                m_waddr = (g == 1) ? int'(lsu_wb_rd) : int'(alu_wb_rd);
                m_wdata = (g == 1) ? lsu_wb_data : alu_wb_data;
                m_we    = (m_waddr != 0);
                m_last  = g;
            end else begin
                m_we = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        bit empty;
        if (model_ok) begin
            g = model_grant();
            empty = 1;
            foreach (m_busy[i]) if (m_busy[i]) empty = 0;
            chk("alu_wb_ready", alu_wb_ready, g == 0);
            chk("lsu_wb_ready", lsu_wb_ready, g == 1);
            chk("rf_we",        rf_we,        m_we);
            chk("rf_waddr",     rf_waddr,     m_waddr);
            chk("rf_wdata",     rf_wdata,     m_wdata);
            chk("rs1_busy",     rs1_busy,     m_busy[issue_rs1]);
            chk("rs2_busy",     rs2_busy,     m_busy[issue_rs2]);
            chk("rd_busy",      rd_busy,      m_busy[issue_rd]);
            chk("sb_empty",     sb_empty,     empty);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 0;
        issue_valid  = 0;
        issue_rd     = 0;
        issue_rs1    = 0;
        issue_rs2    = 0;
        alu_wb_valid = 0;
        alu_wb_rd    = 0;
        alu_wb_data  = '0;
        lsu_wb_valid = 0;
        lsu_wb_rd    = 0;
        lsu_wb_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hs_a, hs_l;
        rst_n = 0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
        step();

        // reset / idle
        #3;
        chk("reset rf_we", rf_we, 0);
        chk("reset sb_empty", sb_empty, 1);
        chk("reset alu_ready", alu_wb_ready, 0);
        chk("reset lsu_ready", lsu_wb_ready, 0);
        chk("reset rf_waddr", rf_waddr, 0);

        // issue x5, ALU writes it back two cycles later
        step();
        issue_valid = 1; issue_rd = 5;
        step();
        issue_valid = 0; issue_rs1 = 5;
        #3 chk("x5 busy after issue", rs1_busy, 1);
        step();
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF;
        #3 chk("x5 alu ready", alu_wb_ready, 1);
        chk("x5 busy at handshake", rs1_busy, 1);
        step();
        alu_wb_valid = 0;
        #3 chk("x5 rf_we", rf_we, 1);
        chk("x5 rf_waddr", rf_waddr, 5);
        chk("x5 rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("x5 busy during commit", rs1_busy, 1);
        step();
        #3 chk("x5 rf_we drop", rf_we, 0);
        chk("x5 busy cleared", rs1_busy, 0);

        // LSU write to x0
        step();
        lsu_wb_valid = 1; lsu_wb_rd = 0; lsu_wb_data = 32'h1234;
        #3 chk("x0 lsu ready", lsu_wb_ready, 1);
        step();
        lsu_wb_valid = 0;
        #3 chk("x0 rf_we", rf_we, 0);
        chk("x0 rf_wdata", rf_wdata, 32'h1234);
        chk("x0 sb_empty", sb_empty, 1);

        // both valid for four cycles: ALU, LSU, ALU, LSU
        step();
        alu_wb_rd = 3; alu_wb_data = 32'hA3;
        lsu_wb_rd = 4; lsu_wb_data = 32'hB4;
        for (int i = 0; i < 4; i++) begin
            alu_wb_valid = 1; lsu_wb_valid = 1;
            #3;
            chk("rr alu_ready", alu_wb_ready, (i % 2) == 0);
            chk("rr lsu_ready", lsu_wb_ready, (i % 2) == 1);
            if (i > 0) chk("rr rf_waddr", rf_waddr, (i % 2 == 1) ? 3 : 4);
            step();
        end
        alu_wb_valid = 0; lsu_wb_valid = 0;
        #3 chk("rr last rf_waddr", rf_waddr, 4);
        chk("rr last rf_wdata", rf_wdata, 32'hB4);

        // issue x7 in the cycle its previous write commits
        step();
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0;
        alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 32'h77;
        step();
        alu_wb_valid = 0;
        issue_valid = 1; issue_rd = 7;
        #3 chk("x7 commit rf_we", rf_we, 1);
        chk("x7 commit rf_waddr", rf_waddr, 7);
        step();
        issue_valid = 0;
        #3 chk("x7 set wins", rd_busy, 1);
        step();
        #3 chk("x7 still busy", rd_busy, 1);

        // flush while ALU writes x9 (and a same-cycle issue that flush overrides)
        issue_valid = 1; issue_rd = 1;
        step();
        issue_rd = 2;
        step();
        issue_valid = 0;
        #3 chk("pre-flush sb_empty", sb_empty, 0);
        step();
        flush = 1; issue_valid = 1; issue_rd = 12;
        alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h99;
        #3 chk("flush alu ready", alu_wb_ready, 1);
        step();
        flush = 0; issue_valid = 0; alu_wb_valid = 0;
        #3 chk("flush sb_empty", sb_empty, 1);
        chk("flush rf_we", rf_we, 1);
        chk("flush rf_waddr", rf_waddr, 9);

        // reset in the middle of a handshake drops the write
        step();
        alu_wb_valid = 1; alu_wb_rd = 10; alu_wb_data = 32'hA;
        rst_n = 0;
        step();
        alu_wb_valid = 0;
        #3 chk("midreset rf_we", rf_we, 0);
        chk("midreset rf_waddr", rf_waddr, 0);
        step();
        rst_n = 1;
        step();

        // randomized traffic; requesters hold until granted
        hs_a = 0; hs_l = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!(alu_wb_valid && !hs_a)) begin
                alu_wb_valid = ($urandom_range(0, 2) != 0);
                alu_wb_rd    = 5'($urandom_range(0, 31));
                alu_wb_data  = $urandom;
            end
            if (!(lsu_wb_valid && !hs_l)) begin
                lsu_wb_valid = ($urandom_range(0, 2) != 0);
                lsu_wb_rd    = 5'($urandom_range(0, 31));
                lsu_wb_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_rd    = 5'($urandom_range(0, 31));
            issue_rs1   = 5'($urandom_range(0, 31));
            issue_rs2   = 5'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 19) == 0);
            rst_n       = ($urandom_range(0, 399) != 0);
            #3;
            hs_a = alu_wb_valid && alu_wb_ready;
            hs_l = lsu_wb_valid && lsu_wb_ready;
            step();
        end
        idle_inputs();
        rst_n = 1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
